// File: rtl/irq_pkg.sv
// Shared types and helpers for the multi-source interrupt arbiter.
package irq_pkg;

   typedef enum logic [1:0] {
      IRQ_IDLE,
      IRQ_REQ,
      IRQ_SERVICE
   } irq_state_t;

   localparam int unsigned IRQ_CAUSE_BASE = 16;

   // Exception code (without the interrupt flag) for a given source index.
   function automatic logic [31:0] mk_cause(input logic [31:0] id);
      return IRQ_CAUSE_BASE + id;
   endfunction

endpackage

// File: rtl/irq_sync.sv
// Multi-flop synchroniser for one asynchronous interrupt line, with a
// rising-edge pulse derived from the synchronised level.
module irq_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic src_i,
   output logic level_o,
   output logic rise_o
);

   logic [STAGES-1:0] chain_q;
   logic              prev_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         chain_q <= '0;
         prev_q  <= 1'b0;
      end else begin
         chain_q <= {chain_q[STAGES-2:0], src_i};
         prev_q  <= chain_q[STAGES-1];
      end
   end

   assign level_o = chain_q[STAGES-1];
   assign rise_o  = chain_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/irq_arbiter.sv
// Multi-source interrupt controller: synchronise, latch/mask, prioritise and
// hand one request to the commit stage. Define IRQ_VECTORED_EN for vectored mtvec mode.
module irq_arbiter
   import irq_pkg::*;
#(
   parameter int unsigned          NUM_IRQ     = 8,
   parameter int unsigned          XLEN        = 32,
   parameter int unsigned          SYNC_STAGES = 2,
   parameter logic [NUM_IRQ-1:0]   EDGE_MASK   = '0,
   localparam int unsigned         IDW         = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [NUM_IRQ-1:0] irq_src_i,
   input  logic [NUM_IRQ-1:0] irq_enable_i,
   input  logic               global_ie_i,
   input  logic [XLEN-1:0]    mtvec_i,
   input  logic               irq_ack_i,
   input  logic               mret_i,
   output logic               irq_req_o,
   output logic [IDW-1:0]     irq_id_o,
   output logic [XLEN-1:0]    irq_cause_o,
   output logic [XLEN-1:0]    irq_pc_o,
   output logic               irq_busy_o,
   output logic [NUM_IRQ-1:0] irq_pending_o
);

   irq_state_t         state_q;
   logic [IDW-1:0]     id_q;
   logic [XLEN-1:0]    cause_q, pc_q;
   logic               req_q, busy_q;
   logic [NUM_IRQ-1:0] pending_q, pending_d;
   logic [NUM_IRQ-1:0] sync_level, sync_rise, clr, cand;
   logic [IDW-1:0]     sel_id;
   logic [XLEN-1:0]    cause_d, pc_d, base;
   logic               ack_taken, withdraw;

   assign ack_taken = (state_q == IRQ_REQ) && irq_ack_i;

   for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_src
      irq_sync #(.STAGES(SYNC_STAGES)) u_sync (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .src_i   (irq_src_i[gi]),
         .level_o (sync_level[gi]),
         .rise_o  (sync_rise[gi])
      );
      assign clr[gi] = ack_taken && (id_q == IDW'(gi));
      // A fresh edge coinciding with the ack of the same source must not be lost.
      assign pending_d[gi] = EDGE_MASK[gi] ? (sync_rise[gi] | (pending_q[gi] & ~clr[gi]))
                                           : sync_level[gi];
   end

   always_comb begin
      cand   = pending_q & irq_enable_i;
      sel_id = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (cand[i]) sel_id = IDW'(i);
      end
   end

   assign cause_d = {1'b1, (XLEN-1)'(mk_cause(32'(sel_id)))};
   assign base    = {mtvec_i[XLEN-1:2], 2'b00};

`ifdef IRQ_VECTORED_EN
   assign pc_d = (mtvec_i[1:0] == 2'b01) ? base + XLEN'({mk_cause(32'(sel_id)), 2'b00}) : base;
`else
   logic unused_mode;
   assign unused_mode = ^mtvec_i[1:0];
   assign pc_d        = base;
`endif

   assign withdraw = !global_ie_i || !irq_enable_i[id_q] || !pending_q[id_q];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IRQ_IDLE;
         id_q      <= '0;
         cause_q   <= '0;
         pc_q      <= '0;
         req_q     <= 1'b0;
         busy_q    <= 1'b0;
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
         case (state_q)
            IRQ_IDLE: begin
               if ((|cand) && global_ie_i) begin
                  state_q <= IRQ_REQ;
                  req_q   <= 1'b1;
                  id_q    <= sel_id;
                  cause_q <= cause_d;
                  pc_q    <= pc_d;
               end
            end
            IRQ_REQ: begin
               // An ack in the same cycle as a withdraw condition still wins.
               if (irq_ack_i) begin
                  state_q <= IRQ_SERVICE;
                  req_q   <= 1'b0;
                  busy_q  <= 1'b1;
               end else if (withdraw) begin
                  state_q <= IRQ_IDLE;
                  req_q   <= 1'b0;
               end
            end
            IRQ_SERVICE: begin
               if (mret_i) begin
                  state_q <= IRQ_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IRQ_IDLE;
               req_q   <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign irq_req_o     = req_q;
   assign irq_id_o      = id_q;
   assign irq_cause_o   = cause_q;
   assign irq_pc_o      = pc_q;
   assign irq_busy_o    = busy_q;
   assign irq_pending_o = pending_q;

endmodule
